// File: rtl/as_clk_gen.sv
// as_clk_gen: programmable slow-clock generator with clamped phases, low-phase stretch and edge strobes
module as_clk_gen #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             en,
  input  logic [CNT_W-1:0] hi_cnt,
  input  logic [CNT_W-1:0] lo_cnt,
  input  logic             stretch,
  output logic             dout,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             running
);
  typedef enum logic [1:0] {IDLE, LOW, STRETCH, HIGH} state_e;
  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(3);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lo_len_q, lo_len_d, hi_len_q, hi_len_d;
  logic             last, entry, dout_d, rise_d, fall_d, run_d;
  // state register, negative-edge clocked so the slow clock is centred against rising-edge samplers
  always_ff @(negedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // next state: en only matters in IDLE and on the last HIGH cycle, stretch only on the last LOW cycle and in STRETCH
  always_comb begin
    last    = (state_q == LOW) ? (cnt_q == lo_len_q) : (cnt_q == hi_len_q);
    state_d = (state_q == IDLE)    ? (en ? LOW : IDLE)
            : (state_q == LOW)     ? (!last ? LOW : stretch ? STRETCH : HIGH)
            : (state_q == STRETCH) ? (stretch ? STRETCH : HIGH)
            :                        (!last ? HIGH : en ? LOW : IDLE);
  end
  // phase counter restarts at 1 on every phase entry and lengths are latched only then; a count never exceeds its length so it cannot wrap
  always_comb begin
    entry    = state_d != state_q;
    cnt_d    = (state_d == LOW || state_d == HIGH) ? (entry ? CNT_W'(1) : cnt_q + CNT_W'(1)) : '0;
    lo_len_d = (entry && state_d == LOW)  ? ((lo_cnt < MIN_LEN) ? MIN_LEN : lo_cnt) : lo_len_q;
    hi_len_d = (entry && state_d == HIGH) ? ((hi_cnt < MIN_LEN) ? MIN_LEN : hi_cnt) : hi_len_q;
  end
  // phase counter and latched lengths
  always_ff @(negedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q    <= '0;
      lo_len_q <= MIN_LEN;
      hi_len_q <= MIN_LEN;
    end else begin
      cnt_q    <= cnt_d;
      lo_len_q <= lo_len_d;
      hi_len_q <= hi_len_d;
    end
  end
  // outputs decoded from the next state so the registered copies line up with the state register
  always_comb begin
    dout_d = state_d == IDLE || state_d == HIGH;
    run_d  = state_d != IDLE;
    rise_d = dout_d & ~dout;
    fall_d = ~dout_d & dout;
  end
  // output registers; reset parks the line high so an aborted phase never leaves a strobe or low level behind
  always_ff @(negedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dout     <= 1'b1;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      running  <= 1'b0;
    end else begin
      dout     <= dout_d;
      rise_stb <= rise_d;
      fall_stb <= fall_d;
      running  <= run_d;
    end
  end
endmodule
